// File: rtl/hex_history_ctrl.sv
// rtl/hex_history_ctrl.sv - six-deep nibble history driving the HEX5..HEX0 digit bank
// Newest entry lives in slot 0; SCROLL mode rotates the visible window at SCROLL_HZ.
module hex_history_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int SCROLL_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [3:0] push_val,
  input  logic       clear,
  input  logic       scroll_en,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] digit5,
  output logic [5:0] blank,
  output logic [2:0] count,
  output logic       full
);

  localparam int TICK_DIV = CLK_HZ / SCROLL_HZ;
  localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_STATIC, ST_SCROLL} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [3:0]    r_slot [6];
  logic [2:0]    r_count;
  logic [2:0]    w_count_nx;
  logic          r_full;
  logic [2:0]    r_rot;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_dig [6];
  logic [5:0]    r_blank;
  logic [2:0]    w_idx [6];
  logic          w_restart;

  assign w_restart = push | clear;

  always_comb begin
    w_count_nx = r_count;
    if (clear)
      w_count_nx = 3'd0;
    else if (push && (r_count != 3'd6))
      w_count_nx = r_count + 3'd1;
  end

  // Mode decisions look at the post-update count, not the current one.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_count_nx >= 3'd2 && scroll_en)
          w_state_nx = ST_SCROLL;
        else if (w_count_nx >= 3'd1 && !scroll_en)
          w_state_nx = ST_STATIC;
      end
      ST_STATIC: begin
        if (w_count_nx == 3'd0)
          w_state_nx = ST_EMPTY;
        else if (scroll_en && w_count_nx >= 3'd2)
          w_state_nx = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (w_count_nx == 3'd0)
          w_state_nx = ST_EMPTY;
        else if (!scroll_en || w_count_nx < 3'd2)
          w_state_nx = ST_STATIC;
      end
      default: w_state_nx = ST_EMPTY;
    endcase
  end

  always_comb begin
    for (int n = 0; n < 6; n++) begin
      w_idx[n] = 3'd0;
      if ((4'(n) + {1'b0, r_rot}) >= 4'd6)
        w_idx[n] = 3'(4'(n) + {1'b0, r_rot} - 4'd6);
      else
        w_idx[n] = 3'(n) + r_rot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++)
        r_slot[i] <= 4'h0;
      r_count <= 3'd0;
      r_full  <= 1'b0;
      r_state <= ST_EMPTY;
      r_rot   <= 3'd0;
      r_presc <= '0;
    end else begin
      if (push && !clear) begin
        for (int i = 5; i >= 1; i--)
          r_slot[i] <= r_slot[i-1];
        r_slot[0] <= push_val;
      end
      r_count <= w_count_nx;
      r_full  <= (w_count_nx == 3'd6);
      r_state <= w_state_nx;
      // Entering SCROLL starts from a zero prescaler so the first step is a full period away.
      if (w_restart || w_state_nx != ST_SCROLL || r_state != ST_SCROLL) begin
        r_presc <= '0;
        r_rot   <= 3'd0;
      end else if (r_presc == TICK_LAST) begin
        r_presc <= '0;
        r_rot   <= (r_rot == 3'd5) ? 3'd0 : r_rot + 3'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 6; n++)
        r_dig[n] <= 4'h0;
      r_blank <= 6'b111111;
    end else begin
      for (int n = 0; n < 6; n++) begin
        r_dig[n]   <= r_slot[w_idx[n]];
        r_blank[n] <= (w_idx[n] >= r_count);
      end
    end
  end

  assign digit0 = r_dig[0];
  assign digit1 = r_dig[1];
  assign digit2 = r_dig[2];
  assign digit3 = r_dig[3];
  assign digit4 = r_dig[4];
  assign digit5 = r_dig[5];
  assign blank  = r_blank;
  assign count  = r_count;
  assign full   = r_full;

endmodule

// File: tb/tb_hex_history_ctrl.sv
// tb/tb_hex_history_ctrl.sv - randomized and directed bench for hex_history_ctrl
// Reference keeps the history as a queue and derives rotation from elapsed scroll time.
module tb_hex_history_ctrl;

  localparam int CLK_HZ    = 8;
  localparam int SCROLL_HZ = 2;
  localparam int TD        = CLK_HZ / SCROLL_HZ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, clear, scroll_en;
  logic [3:0] push_val;
  logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
  logic [5:0] blank;
  logic [2:0] count;
  logic       full;
  logic [3:0] dg [6];

  int n_vec = 0;
  int n_err = 0;

  int hist[$];
  int mode = 0;
  int age  = 0;
  logic [5:0] exp_blank;
  int         exp_dig [6];

  hex_history_ctrl #(.CLK_HZ(CLK_HZ), .SCROLL_HZ(SCROLL_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_val(push_val),
    .clear(clear), .scroll_en(scroll_en),
    .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .digit4(digit4), .digit5(digit5),
    .blank(blank), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  assign dg[0] = digit0;
  assign dg[1] = digit1;
  assign dg[2] = digit2;
  assign dg[3] = digit3;
  assign dg[4] = digit4;
  assign dg[5] = digit5;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int model_rot();
    return (mode == 2) ? (age / TD) % 6 : 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    mode = 0;
    age  = 0;
  endtask

  task automatic model_edge(input logic p, input int v, input logic c, input logic s);
    int prev, n, r, idx;
    r = model_rot();
    for (int k = 0; k < 6; k++) begin
      idx = (k + r) % 6;
      exp_blank[k] = (idx >= hist.size());
      exp_dig[k]   = exp_blank[k] ? 0 : hist[idx];
    end
    prev = mode;
    if (c) hist.delete();
    else if (p) begin
      hist.push_front(v);
      if (hist.size() > 6) void'(hist.pop_back());
    end
    n = hist.size();
    case (mode)
      0: if (n >= 2 && s) mode = 2; else if (n >= 1 && !s) mode = 1;
      1: if (n == 0) mode = 0; else if (s && n >= 2) mode = 2;
      default: if (n == 0) mode = 0; else if (!s || n < 2) mode = 1;
    endcase
    if (p || c || mode != 2 || prev != 2) age = 0;
    else age = (age + 1) % (6 * TD);
  endtask

  task automatic step(input logic p, input int v, input logic c, input logic s);
    push = p; push_val = 4'(v); clear = c; scroll_en = s;
    @(posedge clk);
    model_edge(p, v, c, s);
    @(negedge clk);
    chk("count", int'(count), hist.size());
    chk("full", int'(full), int'(hist.size() == 6));
    chk("blank", int'(blank), int'(exp_blank));
    for (int k = 0; k < 6; k++)
      if (!exp_blank[k]) chk($sformatf("digit%0d", k), int'(dg[k]), exp_dig[k]);
  endtask

  task automatic check_reset_state();
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_blank", int'(blank), 'h3f);
    for (int k = 0; k < 6; k++) chk($sformatf("rst_digit%0d", k), int'(dg[k]), 0);
  endtask

  initial begin
    int guard;
    logic s;
    rst_n = 1'b0; push = 0; clear = 0; scroll_en = 0; push_val = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);

    step(1, 'h3, 0, 0); step(1, 'h7, 0, 0); step(1, 'hA, 0, 0);
    chk("t2_count", int'(count), 3);
    step(0, 0, 0, 0);
    chk("t2_d0", int'(digit0), 'hA);
    chk("t2_d1", int'(digit1), 'h7);
    chk("t2_d2", int'(digit2), 'h3);
    chk("t2_blank", int'(blank), 'b111000);

    step(0, 0, 1, 0);
    for (int v = 1; v <= 7; v++) step(1, v, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_full", int'(full), 1);
    chk("t3_d5", int'(digit5), 2);
    chk("t3_d0", int'(digit0), 7);
    chk("t3_blank", int'(blank), 0);

    step(0, 0, 1, 0);
    for (int v = 1; v <= 4; v++) step(1, v, 0, 0);
    step(1, 9, 1, 0);
    chk("t4_count", int'(count), 0);
    step(0, 0, 0, 0);
    chk("t4_blank", int'(blank), 'h3f);

    step(1, 'h3, 0, 0); step(1, 'h7, 0, 0); step(1, 'hA, 0, 0);
    step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);
    chk("t5_d0", int'(digit0), 'h7);
    chk("t5_d1", int'(digit1), 'h3);
    chk("t5_d5", int'(digit5), 'hA);
    chk("t5_blank", int'(blank), 'b011100);
    repeat (20) step(0, 0, 0, 1);
    chk("t5_wrap_d0", int'(digit0), 'hA);
    chk("t5_wrap_blank", int'(blank), 'b111000);

    guard = 0;
    while (model_rot() != 2 && guard < 100) begin
      step(0, 0, 0, 1);
      guard++;
    end
    chk("t6_reach_rot2", int'(guard < 100), 1);
    step(1, 5, 0, 1);
    step(0, 0, 0, 1);
    chk("t6_d0_new", int'(digit0), 5);
    repeat (3) step(0, 0, 0, 1);
    chk("t6_d0_hold", int'(digit0), 5);
    step(0, 0, 0, 1);
    chk("t6_d0_step", int'(digit0), 'hA);
    step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    chk("t6_static_d0", int'(digit0), 5);
    chk("t6_static_blank", int'(blank), 'b110000);

    s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) s = ~s;
      if (i == 1500) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ((i / 200) % 2 == 0)
        step($urandom_range(0, 99) < 40, $urandom_range(0, 15), $urandom_range(0, 99) < 5, s);
      else
        step($urandom_range(0, 99) < 4, $urandom_range(0, 15), $urandom_range(0, 999) < 5, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hex_history_ctrl.md
# hex_history_ctrl

Sequencing controller for the six-digit seven-segment display bank of the DE10-Lite labs. It captures 4-bit results from the adder/datapath on a push strobe into a 6-deep nibble history. It drives the six per-digit 4-bit codes plus blank flags that feed the existing per-digit `sevenseg` decoder instances. An optional scroll mode rotates the history across HEX5..HEX0 at a fixed rate derived from the system clock.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `SCROLL_HZ`, 2, scroll step rate in Hz. `TICK_DIV = CLK_HZ/SCROLL_HZ` must be ≥ 2.
- `clk` input 1: system clock; all state on rising edge.
- `rst_n` input 1: reset; one clock, asynchronous, active-low.
- `push` input 1: single-cycle strobe; capture `push_val`.
- `push_val` input 4: value to record (adder sum).
- `clear` input 1: single-cycle strobe; empty the history.
- `scroll_en` input 1: level; 1 = rotate display, 0 = static.
- `digit0`..`digit5` output 4 each: nibble code for HEX0..HEX5 decoder.
- `blank` output 6: bit N = 1 forces HEXN dark.
- `count` output 3: number of valid entries, 0..6.
- `full` output 1: `count == 6`.

## Operation
- Storage is `slot[0..5]`, 4 bits each; `slot[0]` is the newest entry.
- Push (`push`=1, `clear`=0):
  - `slot[i] <= slot[i-1]` for i=5..1; `slot[0] <= push_val`.
  - `count <= min(count+1, 6)`.
  - When full, `slot[5]` (the oldest entry) is discarded silently.
- Clear has priority over push in the same cycle:
  - `count <= 0`; slots are not required to be zeroed.
  - The push in that cycle is dropped.
- Rotation offset `rot` (0..5), used only in SCROLL:
  - Display position N shows `slot[(N+rot) mod 6]`.
  - It is blanked when that index is ≥ `count`.
- In EMPTY and STATIC, `rot` = 0, so position N shows `slot[N]` and `blank[N] = (N >= count)`.
- Mode FSM, evaluated each cycle after the push/clear update; `count` below is the updated value:
  - EMPTY: `count`=0. Go to STATIC when `count` ≥ 1 and `scroll_en`=0. Go to SCROLL when `count` ≥ 2 and `scroll_en`=1.
  - STATIC: go to EMPTY when `count`=0. Go to SCROLL when `scroll_en`=1 and `count` ≥ 2.
  - SCROLL: go to EMPTY when `count`=0. Go to STATIC when `scroll_en`=0 or `count` < 2.
  - Leaving SCROLL forces `rot` <= 0 and clears the prescaler.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only in SCROLL; it is held at 0 in every other state.
  - A tick occurs on the cycle it equals `TICK_DIV`-1. That cycle it wraps to 0 and `rot <= (rot+1) mod 6`.
- Any push or clear resets `rot` to 0 and the prescaler to 0. This takes priority over a coincident tick.
- `push` while `clear`=0 and full: still accepted; `full` stays 1.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `count`=0, `full`=0, state EMPTY, `rot`=0, prescaler=0.
  - `digit0`..`digit5` = 4'h0; `blank` = 6'b111111.
- Internal update latency: `push`/`clear` sampled at edge k updates slots, `count`, `full` and state at edge k.
- Display latency: `digitN`/`blank` are registered from the edge-k state and change at edge k+1, one cycle behind `count`.
- Scroll period is exactly `TICK_DIV` cycles per `rot` step. The first step comes `TICK_DIV` cycles after entering SCROLL or after the last push/clear.
- Back-to-back pushes on consecutive cycles are each accepted; there is no throughput limit.
- `rst_n` released mid-scroll: the block restarts from EMPTY; history is lost.

## Test plan
Scroll scenarios use `CLK_HZ`=8, `SCROLL_HZ`=2, giving `TICK_DIV`=4.
- Reset, then idle → `blank`=6'b111111, all digits 0, `count`=0, `full`=0.
- Push 3, 7, A on consecutive cycles, `scroll_en`=0 → `count`=3. One cycle later: `digit0`=A, `digit1`=7, `digit2`=3, `blank`=6'b111000.
- Push 1..7 (7 pushes) → `count`=6, `full`=1. Then `digit5..digit0` = 2,3,4,5,6,7; value 1 is dropped; `blank`=0.
- Assert `clear` and `push`(val 9) in the same cycle with `count`=4 → `count`=0, `blank`=6'b111111 next cycle; 9 is not stored.
- History A,7,3 (`slot[0..2]`), set `scroll_en`=1:
  - After 4 cycles `rot`=1: `digit0`=7, `digit1`=3, `digit5`=A, `blank`=6'b011100.
  - After 24 cycles `rot` has returned to 0.
- During SCROLL with `rot`=2, push 5 → `rot`=0 and `digit0`=5 the next display update. The next step occurs 4 cycles after the push. Then drop `scroll_en` → STATIC, `rot` held 0.
